// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: FSM states, opcodes,
// datapath select codes, ALU controls and trap causes.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_TRAP
    } state_t;

    typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} aluop_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REGA  = 2'b10;

    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       retire;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] imm_src;
    } ctl_t;

endpackage

// File: rtl/mc_control_if.sv
// Bundle between the control unit (master) and the instruction register,
// datapath and unified memory port (slave).
interface mc_control_if #(parameter int INSTRET_WIDTH = 32);
    logic [6:0]               op;
    logic [2:0]               funct3;
    logic                     funct7_5;
    logic                     Zero;
    logic                     mem_ready;
    logic                     mem_req;
    logic                     MemWrite;
    logic                     AdrSrc;
    logic                     IRWrite;
    logic                     PCWrite;
    logic                     RegWrite;
    logic [1:0]               ResultSrc;
    logic [1:0]               ALUSrcA;
    logic [1:0]               ALUSrcB;
    logic [1:0]               ImmSrc;
    logic [2:0]               ALUctrl;
    logic                     retire;
    logic [INSTRET_WIDTH-1:0] instret;
    logic [1:0]               trap_cause;

    modport master (
        input  op, funct3, funct7_5, Zero, mem_ready,
        output mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUctrl, retire, instret, trap_cause
    );
    modport slave (
        output op, funct3, funct7_5, Zero, mem_ready,
        input  mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUctrl, retire, instret, trap_cause
    );
endinterface

// File: rtl/alu_decoder.sv
// ALU operation decode from the FSM's ALUOp class; flags funct3 values the
// R/I subset does not implement.
module alu_decoder import mc_pkg::*; (
    input  aluop_t     aluop,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       op5,
    output logic [2:0] alu_ctrl,
    output logic       illegal
);
    always_comb begin
        alu_ctrl = ALU_ADD;
        illegal  = 1'b0;
        case (aluop)
            ALUOP_SUB:   alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // only R-type (op[5]=1) has a sub; addi ignores instr[30]
                    3'b000:  alu_ctrl = (op5 & funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b110:  alu_ctrl = ALU_OR;
                    3'b111:  alu_ctrl = ALU_AND;
                    default: illegal  = 1'b1;
                endcase
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mc_control.sv
// Multi-cycle RV32I control FSM with retired-instruction counter, memory-wait
// timeout and a sticky trap state.
module mc_control import mc_pkg::*; #(
    parameter int DATA_WIDTH    = 32,
    parameter int TIMEOUT       = 16,
    parameter int INSTRET_WIDTH = 32
) (
    input logic          clk,
    input logic          rst,
    mc_control_if.master bus
);
    localparam int TW = $clog2(TIMEOUT);

    if (TIMEOUT < 2 || DATA_WIDTH < 1) begin : g_param_chk
        $error("mc_control: TIMEOUT must be at least 2");
    end

    state_t                   state;
    logic [TW-1:0]            tcnt;
    logic [INSTRET_WIDTH-1:0] instret;
    logic [1:0]               trap_cause;
    aluop_t                   aluop;
    logic [2:0]               alu_ctrl;
    logic                     funct_illegal;
    ctl_t                     ctl;
    logic                     br_legal, mem_wait, tmo;

    assign br_legal = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001);
    assign mem_wait = ctl.mem_req & ~bus.mem_ready;
    assign tmo      = mem_wait && (tcnt == TW'(TIMEOUT - 1));

    always_comb begin
        case (state)
            S_BRANCH:         aluop = ALUOP_SUB;
            S_EXECR, S_EXECI: aluop = ALUOP_FUNCT;
            default:          aluop = ALUOP_ADD;
        endcase
    end

    alu_decoder u_alu_dec (
        .aluop   (aluop),
        .funct3  (bus.funct3),
        .funct7_5(bus.funct7_5),
        .op5     (bus.op[5]),
        .alu_ctrl(alu_ctrl),
        .illegal (funct_illegal)
    );

    // Moore decode of state; everything is held at zero while reset is low
    always_comb begin
        ctl = '0;
        if (rst) begin
            case (state)
                S_FETCH: begin
                    ctl.mem_req    = 1'b1;
                    ctl.alu_src_b  = SRCB_FOUR;
                    ctl.result_src = RES_ALURES;
                    ctl.ir_write   = bus.mem_ready;
                    ctl.pc_write   = bus.mem_ready;
                end
                S_DECODE: begin
                    ctl.alu_src_a = SRCA_OLDPC;
                    ctl.alu_src_b = SRCB_IMM;
                    ctl.imm_src   = IMM_B;
                end
                S_MEMADR: begin
                    ctl.alu_src_a = SRCA_REGA;
                    ctl.alu_src_b = SRCB_IMM;
                    ctl.imm_src   = (bus.op == OP_STORE) ? IMM_S : IMM_I;
                end
                S_MEMREAD: begin
                    ctl.mem_req = 1'b1;
                    ctl.adr_src = 1'b1;
                end
                S_MEMWB: begin
                    ctl.result_src = RES_DATA;
                    ctl.reg_write  = 1'b1;
                    ctl.retire     = 1'b1;
                end
                S_MEMWRITE: begin
                    ctl.mem_req   = 1'b1;
                    ctl.mem_write = 1'b1;
                    ctl.adr_src   = 1'b1;
                    ctl.retire    = bus.mem_ready;
                end
                S_EXECR: ctl.alu_src_a = SRCA_REGA;
                S_EXECI: begin
                    ctl.alu_src_a = SRCA_REGA;
                    ctl.alu_src_b = SRCB_IMM;
                    ctl.imm_src   = IMM_I;
                end
                S_ALUWB: begin
                    ctl.reg_write = 1'b1;
                    ctl.retire    = 1'b1;
                end
                S_BRANCH: begin
                    ctl.alu_src_a = SRCA_REGA;
                    ctl.retire    = br_legal;
                    ctl.pc_write  = br_legal & (bus.funct3[0] ? ~bus.Zero : bus.Zero);
                end
                S_JAL: begin
                    ctl.alu_src_a = SRCA_OLDPC;
                    ctl.alu_src_b = SRCB_FOUR;
                    ctl.pc_write  = 1'b1;
                    ctl.imm_src   = IMM_J;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_FETCH;
            tcnt       <= '0;
            instret    <= '0;
            trap_cause <= TRAP_NONE;
        end else begin
            tcnt <= mem_wait ? tcnt + TW'(1) : '0;
            if (ctl.retire) instret <= instret + INSTRET_WIDTH'(1);
            if (tmo) begin
                state      <= S_TRAP;
                trap_cause <= TRAP_TIMEOUT;
            end else begin
                case (state)
                    S_FETCH:    if (bus.mem_ready) state <= S_DECODE;
                    S_DECODE: begin
                        case (bus.op)
                            OP_LOAD, OP_STORE: state <= S_MEMADR;
                            OP_RTYPE:          state <= S_EXECR;
                            OP_ITYPE:          state <= S_EXECI;
                            OP_BRANCH:         state <= S_BRANCH;
                            OP_JAL:            state <= S_JAL;
                            default: begin
                                state      <= S_TRAP;
                                trap_cause <= TRAP_ILLEGAL;
                            end
                        endcase
                    end
                    S_MEMADR:   state <= (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
                    S_MEMREAD:  if (bus.mem_ready) state <= S_MEMWB;
                    S_MEMWB:    state <= S_FETCH;
                    S_MEMWRITE: if (bus.mem_ready) state <= S_FETCH;
                    S_EXECR, S_EXECI: begin
                        if (funct_illegal) begin
                            state      <= S_TRAP;
                            trap_cause <= TRAP_ILLEGAL;
                        end else begin
                            state <= S_ALUWB;
                        end
                    end
                    S_ALUWB:    state <= S_FETCH;
                    S_BRANCH: begin
                        if (br_legal) begin
                            state <= S_FETCH;
                        end else begin
                            state      <= S_TRAP;
                            trap_cause <= TRAP_ILLEGAL;
                        end
                    end
                    S_JAL:      state <= S_ALUWB;
                    S_TRAP:     state <= S_TRAP;
                    default:    state <= S_FETCH;
                endcase
            end
        end
    end

    assign bus.mem_req    = ctl.mem_req;
    assign bus.MemWrite   = ctl.mem_write;
    assign bus.AdrSrc     = ctl.adr_src;
    assign bus.IRWrite    = ctl.ir_write;
    assign bus.PCWrite    = ctl.pc_write;
    assign bus.RegWrite   = ctl.reg_write;
    assign bus.retire     = ctl.retire;
    assign bus.ResultSrc  = ctl.result_src;
    assign bus.ALUSrcA    = ctl.alu_src_a;
    assign bus.ALUSrcB    = ctl.alu_src_b;
    assign bus.ImmSrc     = ctl.imm_src;
    assign bus.ALUctrl    = rst ? alu_ctrl : ALU_ADD;
    assign bus.instret    = instret;
    assign bus.trap_cause = trap_cause;

endmodule

// File: tb/tb_mc_control.sv
// Randomized instruction stream against a per-instruction model of cycle
// counts, handshake activity and retire bookkeeping, plus directed trap/reset cases.
module tb_mc_control;
    localparam int IW = 4;
    localparam int TO = 16;
    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BR = 4, K_JAL = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    mc_control_if #(.INSTRET_WIDTH(IW)) bus ();

    mc_control #(.DATA_WIDTH(32), .TIMEOUT(TO), .INSTRET_WIDTH(IW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    int exp_instret = 0;
    int wq[$];
    bit force_low = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] opc(input int k);
        case (k)
            K_LW:    return 7'b0000011;
            K_SW:    return 7'b0100011;
            K_R:     return 7'b0110011;
            K_I:     return 7'b0010011;
            K_BR:    return 7'b1100011;
            default: return 7'b1101111;
        endcase
    endfunction

    function automatic logic [2:0] exp_alu(input int k, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (k == K_R && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            default: return 3'b010;
        endcase
    endfunction

    // memory side: each request phase waits wq[0] cycles, then completes
    task automatic respond();
        if (force_low) bus.mem_ready = 1'b0;
        else if (bus.mem_req) begin
            if (wq.size() != 0 && wq[0] > 0) begin
                bus.mem_ready = 1'b0;
                wq[0] = wq[0] - 1;
            end else begin
                bus.mem_ready = 1'b1;
                if (wq.size() != 0) void'(wq.pop_front());
            end
        end else bus.mem_ready = 1'($urandom_range(0, 1));
    endtask

    function automatic logic [5:0] enables();
        return {bus.mem_req, bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.retire};
    endfunction

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        check({tag, ".rst_en"}, 32'(enables()), 0);
        check({tag, ".rst_instret"}, 32'(bus.instret), 0);
        check({tag, ".rst_trap"}, 32'(bus.trap_cause), 0);
        exp_instret = 0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic run_instr(input int k, input logic [2:0] f3, input logic f7,
                             input logic z, input int fw, input int mw, input string tag);
        int L, rcnt, rat, req, mwc, pcw, rgw, irw;
        logic [2:0] alu;
        bit is_mem, taken;
        is_mem = (k == K_LW || k == K_SW);
        taken  = f3[0] ? !z : z;
        bus.op = opc(k); bus.funct3 = f3; bus.funct7_5 = f7; bus.Zero = z;
        wq.delete();
        wq.push_back(fw);
        if (is_mem) wq.push_back(mw);
        case (k)
            K_LW:    L = 5;
            K_BR:    L = 3;
            default: L = 4;
        endcase
        L = L + fw + (is_mem ? mw : 0);
        rcnt = 0; rat = 0; req = 0; mwc = 0; pcw = 0; rgw = 0; irw = 0; alu = 3'b000;
        for (int c = 1; c <= L; c++) begin
            @(negedge clk);
            respond();
            #1;
            if (bus.retire) begin rcnt++; rat = c; end
            req += int'(bus.mem_req);
            mwc += int'(bus.MemWrite);
            pcw += int'(bus.PCWrite);
            rgw += int'(bus.RegWrite);
            irw += int'(bus.IRWrite);
            if (c == fw + 3) alu = bus.ALUctrl;
        end
        @(posedge clk); #1;
        exp_instret = (exp_instret + 1) % (1 << IW);
        check({tag, ".retire_cnt"}, rcnt, 1);
        check({tag, ".retire_at"}, rat, L);
        check({tag, ".mem_req_cyc"}, req, 1 + fw + (is_mem ? 1 + mw : 0));
        check({tag, ".memwrite_cyc"}, mwc, (k == K_SW) ? 1 + mw : 0);
        check({tag, ".pcwrite_cnt"}, pcw, 1 + int'(k == K_JAL) + int'(k == K_BR && taken));
        check({tag, ".regwrite_cnt"}, rgw, int'(k == K_LW || k == K_R || k == K_I || k == K_JAL));
        check({tag, ".irwrite_cnt"}, irw, 1);
        if (k == K_R || k == K_I) check({tag, ".aluctrl"}, alu, exp_alu(k, f3, f7));
        check({tag, ".instret"}, 32'(bus.instret), exp_instret);
        check({tag, ".next_fetch"}, 32'(bus.mem_req), 1);
    endtask

    task automatic run_trap(input logic [6:0] op, input logic [2:0] f3, input string tag);
        int rcnt, req, pcw;
        bus.op = op; bus.funct3 = f3; bus.funct7_5 = 1'b0; bus.Zero = 1'b1;
        wq.delete(); wq.push_back(0);
        rcnt = 0; req = 0; pcw = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            respond();
            #1;
            rcnt += int'(bus.retire);
            req  += int'(bus.mem_req);
            pcw  += int'(bus.PCWrite);
        end
        check({tag, ".retire_cnt"}, rcnt, 0);
        check({tag, ".mem_req_cyc"}, req, 1);
        check({tag, ".pcwrite_cnt"}, pcw, 1);
        check({tag, ".cause"}, 32'(bus.trap_cause), 1);
        check({tag, ".instret"}, 32'(bus.instret), exp_instret);
        do_reset({tag, ".reset"});
    endtask

    initial begin
        int k, cnt, irw;
        logic [2:0] f3;
        logic [2:0] rf3 [4] = '{3'b000, 3'b010, 3'b110, 3'b111};
        bus.op = '0; bus.funct3 = '0; bus.funct7_5 = 1'b0; bus.Zero = 1'b0; bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        do_reset("init");

        run_instr(K_LW, 3'b010, 1'b0, 1'b0, 0, 0, "lw0");
        run_instr(K_R, 3'b000, 1'b1, 1'b0, 0, 0, "rsub");
        run_instr(K_BR, 3'b000, 1'b0, 1'b1, 0, 0, "beq_z1");
        run_instr(K_BR, 3'b000, 1'b0, 1'b0, 0, 0, "beq_z0");
        run_instr(K_BR, 3'b001, 1'b0, 1'b1, 0, 0, "bne_z1");
        run_instr(K_BR, 3'b001, 1'b0, 1'b0, 0, 0, "bne_z0");
        run_instr(K_SW, 3'b010, 1'b0, 1'b0, 0, 3, "sw_wait3");
        run_instr(K_JAL, 3'b000, 1'b0, 1'b0, 1, 0, "jal");

        // long enough to wrap the 4-bit instret several times
        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 5);
            if (k == K_BR) f3 = 3'($urandom_range(0, 1));
            else if (k == K_R || k == K_I) f3 = rf3[$urandom_range(0, 3)];
            else f3 = 3'($urandom_range(0, 7));
            run_instr(k, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), $urandom_range(0, 4), $sformatf("rnd%0d", n));
        end

        // reset in the middle of a waiting load
        bus.op = 7'b0000011;
        wq.delete(); wq.push_back(0); wq.push_back(10);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            respond();
            #1;
        end
        check("abort.in_memread", 32'({bus.mem_req, bus.AdrSrc}), 32'h3);
        do_reset("abort");
        run_instr(K_LW, 3'b010, 1'b0, 1'b0, 0, 0, "after_abort");

        run_trap(7'b1111111, 3'b000, "ill_op");
        run_trap(7'b0110011, 3'b001, "ill_rf3");
        run_trap(7'b1100011, 3'b100, "ill_bf3");

        // memory never answers the fetch
        bus.op = 7'b0000011;
        force_low = 1'b1;
        cnt = 0; irw = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            respond();
            #1;
            irw += int'(bus.IRWrite);
            if (!bus.mem_req) break;
            cnt++;
        end
        force_low = 1'b0;
        check("tmo.req_cycles", cnt, TO);
        check("tmo.cause", 32'(bus.trap_cause), 2);
        check("tmo.irwrite", irw, 0);
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus.mem_ready = 1'($urandom_range(0, 1));
            #1;
            cnt += int'(bus.mem_req) + int'(bus.retire);
        end
        check("tmo.sticky_idle", cnt, 0);
        check("tmo.sticky_cause", 32'(bus.trap_cause), 2);
        do_reset("tmo");
        run_instr(K_I, 3'b110, 1'b0, 1'b0, 0, 0, "recover");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle control unit for the next-generation RV32I core. It replaces the single-cycle decode path with a state machine that sequences fetch, decode, execute, memory and writeback over several cycles, using one shared instruction/data memory behind a ready handshake. It also owns a retired-instruction counter, a memory-wait timeout and a sticky trap state. It sits between the instruction register/datapath and the unified memory port in the multi-cycle top.

## Interface
Parameters:
- DATA_WIDTH, 32, datapath width (informational; sets no port here)
- TIMEOUT, 16, maximum wait cycles for mem_ready before trapping (≥2)
- INSTRET_WIDTH, 32, width of the retired-instruction counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low (rst=0 resets)
- op  in  7  instr[6:0] from the instruction register
- funct3  in  3  instr[14:12]
- funct7_5  in  1  instr[30]
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current transfer this cycle
- mem_req  out  1  memory transfer request
- MemWrite  out  1  transfer is a write (valid with mem_req)
- AdrSrc  out  1  0=PC, 1=ALUOut
- IRWrite  out  1  load instruction register and OldPC
- PCWrite  out  1  load PC from Result
- RegWrite  out  1  register-file write enable
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=RegA
- ALUSrcB  out  2  00=RegB, 01=ImmExt, 10=constant 4
- ImmSrc  out  2  00=I, 01=S, 10=B, 11=J
- ALUctrl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- retire  out  1  one-cycle pulse in an instruction's final cycle
- instret  out  INSTRET_WIDTH  retired-instruction count
- trap_cause  out  2  00 none, 01 illegal opcode, 10 memory timeout

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP.
- FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUctrl=add, ResultSrc=10. On mem_req&mem_ready: IRWrite=1, PCWrite=1, go to DECODE. Otherwise stay in FETCH.
- DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=B, add (branch target to ALUOut). Next state by op:
  - 0000011 → MEMADR
  - 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - anything else → TRAP with cause 01
- MEMADR: RegA+ImmExt, add; ImmSrc=S for stores, I for loads. Loads go to MEMREAD, stores to MEMWRITE.
- MEMREAD: mem_req=1, AdrSrc=1. Stays in MEMREAD until mem_ready, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, retire, then FETCH.
- MEMWRITE: mem_req=1, MemWrite=1, AdrSrc=1. Stays until mem_ready; in the completion cycle asserts retire, then FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00. EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=I. Both go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, retire, then FETCH.
- BRANCH: RegA−RegB, ResultSrc=00, retire, then FETCH.
  - funct3 000 (beq): PCWrite=Zero.
  - funct3 001 (bne): PCWrite=!Zero.
  - Any other funct3 goes to TRAP with cause 01, no retire.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, ImmSrc=J, then ALUWB (writes link).
- ALUctrl decode (R/I ops, from funct3/funct7_5/op[5]):
  - 000: sub when op[5] & funct7_5, else add
  - 010: slt
  - 110: or
  - 111: and
  - Other funct3 values go to TRAP with cause 01, from EXECR/EXECI.
- Timeout: a counter clears whenever mem_req is 0 or mem_ready is 1, and increments while mem_req=1 and mem_ready=0. When it reaches TIMEOUT−1 with mem_ready still 0, go to TRAP with cause 10.
- TRAP: all enables 0, mem_req=0. The state is sticky until reset; trap_cause holds.
- instret increments on every retire and wraps modulo 2^INSTRET_WIDTH.

## Timing
- Reset (rst=0): state=FETCH, instret=0, trap_cause=00, timeout counter=0. While rst=0 every output enable (mem_req, MemWrite, IRWrite, PCWrite, RegWrite, retire) is forced to 0. Selects are don't-care, driven 0.
- Reset asserted mid-operation aborts immediately; there is no retire and no partial write.
- Outputs are Moore, decoded from state, except for three inputs:
  - IRWrite/PCWrite in FETCH are qualified by mem_ready.
  - retire in MEMWRITE is qualified by mem_ready.
  - PCWrite in BRANCH uses Zero.
- Cycles per instruction with zero-wait memory (mem_ready=1 in the first request cycle):
  - lw 5
  - sw 4
  - R 4
  - I 4
  - beq/bne 3
  - jal 4
- Each wait cycle adds one cycle.
- instret updates on the edge ending the retire cycle.

## Structure
- mc_pkg holds:
  - the state enum
  - opcode constants
  - ALUctrl encodings
  - ResultSrc/ALUSrcA/ALUSrcB/ImmSrc select encodings
  - trap_cause codes
- Sub-module alu_decoder: combinational ALUctrl plus illegal flag, from an ALUOp class, funct3, funct7_5 and op[5].

## Test plan
- Release rst with mem_ready=1, lw opcode 0000011 → states FETCH,DECODE,MEMADR,MEMREAD,MEMWB; retire in cycle 5; instret=1.
- R-type sub (funct3=000, funct7_5=1) → ALUctrl=001 in EXECR; RegWrite=1 in ALUWB; 4 cycles.
- beq with Zero=1 then Zero=0 → PCWrite=1 then 0 in BRANCH; bne inverts; each takes 3 cycles and retires.
- sw with mem_ready low for 3 cycles in MEMWRITE → MemWrite held 4 cycles; retire only in the ready cycle; 7 cycles total.
- mem_ready held low in FETCH with TIMEOUT=16 → TRAP after 16 request cycles; trap_cause=10; mem_req=0 afterwards.
- Illegal opcode 1111111 → TRAP from DECODE with cause 01, no retire. Then:
  - Asserting rst mid-MEMREAD returns to FETCH with instret=0.
  - instret preset near max via 2^INSTRET_WIDTH retires, run with INSTRET_WIDTH=4, wraps 15→0.
